// File: rtl/scanchain_writer_if.sv
// Write-command handshake between the UART scan-command client
// and the scan-chain writer.
interface scanchain_writer_if #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160
);
  logic                    write_valid;
  logic                    write_ready;
  logic [ADDR_BITS-1:0]    write_addr;
  logic [PAYLOAD_BITS-1:0] write_payload;
  logic                    write_reset;

  modport master (
    output write_valid,
    output write_addr,
    output write_payload,
    output write_reset,
    input  write_ready
  );

  modport slave (
    input  write_valid,
    input  write_addr,
    input  write_payload,
    input  write_reset,
    output write_ready
  );
endinterface

// File: rtl/scanchain_writer.sv
// Serialises write commands onto the chip scan-chain pins.
// Optional readback of scan_out: define SCANCHAIN_WRITER_READBACK_EN.
module scanchain_writer #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160,
  parameter int CLK_DIV      = 4
) (
  input  logic clk,
  input  logic reset,
  scanchain_writer_if.slave wr,
  output logic scan_clk,
  output logic scan_en,
  output logic scan_in,
  output logic scan_update,
  output logic scan_reset
`ifdef SCANCHAIN_WRITER_READBACK_EN
  ,
  input  logic scan_out,
  output logic [ADDR_BITS+PAYLOAD_BITS-1:0] readback_data,
  output logic readback_valid
`endif
);

  localparam int N  = ADDR_BITS + PAYLOAD_BITS;
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2(N + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] PH_HALF  = PW'(CLK_DIV);
  localparam logic [PW-1:0] UPD_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    RST
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] phase, phase_n;
  logic [BW-1:0] bitc, bitc_n;
  logic [N-1:0]  sh, sh_n;
  logic          accept;

  assign wr.write_ready = (state == IDLE);
  assign accept = wr.write_valid && wr.write_ready;

  // Next-state, phase/bit counting and shift-register update.
  always_comb begin
    state_n = state;
    phase_n = phase;
    bitc_n  = bitc;
    sh_n    = sh;
    unique case (state)
      IDLE: begin
        if (accept) begin
          phase_n = '0;
          bitc_n  = '0;
          if (wr.write_reset) begin
            state_n = RST;
          end else begin
            state_n = SHIFT;
            sh_n    = {wr.write_payload, wr.write_addr};
          end
        end
      end
      SHIFT: begin
        if (phase == PH_LAST) begin
          phase_n = '0;
          if (bitc == BIT_LAST) begin
            state_n = UPDATE;
          end else begin
            bitc_n = bitc + 1'b1;
            sh_n   = sh >> 1;
          end
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      UPDATE: begin
        if (phase == UPD_LAST) begin
          state_n = IDLE;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      RST: begin
        if (phase == PH_LAST) begin
          state_n = IDLE;
          phase_n = '0;
        end else begin
          phase_n = phase + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and counters; pins registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      bitc        <= '0;
      sh          <= '0;
      scan_clk    <= 1'b0;
      scan_en     <= 1'b0;
      scan_in     <= 1'b0;
      scan_update <= 1'b0;
      scan_reset  <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      bitc        <= bitc_n;
      sh          <= sh_n;
      scan_en     <= (state_n == SHIFT);
      scan_in     <= (state_n == SHIFT) && sh_n[0];
      scan_clk    <= (state_n == SHIFT) && (phase_n >= PH_HALF);
      scan_update <= (state_n == UPDATE);
      scan_reset  <= (state_n == RST);
    end
  end

`ifdef SCANCHAIN_WRITER_READBACK_EN
  // Capture scan_out in the first high scan_clk cycle of each bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else begin
      readback_valid <= (state == UPDATE) && (phase == UPD_LAST);
      if ((state == SHIFT) && (phase == PH_HALF)) begin
        readback_data[bitc] <= scan_out;
      end
    end
  end
`endif

endmodule
